// File: rtl/bcnn_popcount_drain.sv
// Thresholds popcounts into activation bits, packs them LSB-first, and queues the words on a valid/ready stream.
// A word is visible one cycle after it is pushed; the input side never stalls, and a word that finds the FIFO full is dropped and flagged.
module bcnn_popcount_drain #(
  parameter int SUM_WIDTH  = 4,
  parameter int PACK_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [SUM_WIDTH-1:0]  sum_in,
  input  logic [SUM_WIDTH-1:0]  thr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK_WIDTH-1:0] out_data,
  output logic [LEN_W-1:0]      out_len,
  output logic                  overflow,
  output logic [LEN_W-1:0]      bit_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PACK_WIDTH-1:0] r_pack;
  logic [LEN_W-1:0]      r_bit_cnt;
  logic [PACK_WIDTH-1:0] r_mem_dat [FIFO_DEPTH];
  logic [LEN_W-1:0]      r_mem_len [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic [PACK_WIDTH-1:0] w_pack_nxt;
  logic [LEN_W-1:0]      w_cnt_nxt;
  logic                  w_act;
  logic                  w_word_done;
  logic                  w_flush_push;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_drop;

  assign w_act = (sum_in >= thr);

  always_comb begin
    w_pack_nxt = r_pack;
    for (int i = 0; i < PACK_WIDTH; i++) begin
      if (valid_in && (r_bit_cnt == LEN_W'(i))) w_pack_nxt[i] = w_act;
    end
  end

  // The current sample is packed before flush looks at the count, so a flush
  // coinciding with the last bit of a full word adds nothing extra.
  assign w_cnt_nxt    = valid_in ? (r_bit_cnt + LEN_W'(1)) : r_bit_cnt;
  assign w_word_done  = valid_in && (w_cnt_nxt == LEN_W'(PACK_WIDTH));
  assign w_flush_push = flush && !w_word_done && (w_cnt_nxt != '0);
  assign w_push       = w_word_done || w_flush_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack    <= '0;
      r_bit_cnt <= '0;
    end else if (w_push) begin
      r_pack    <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_pack    <= w_pack_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem_dat[r_wr_ptr] <= w_pack_nxt;
      r_mem_len[r_wr_ptr] <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_data = out_valid ? r_mem_dat[r_rd_ptr] : '0;
  assign out_len  = out_valid ? r_mem_len[r_rd_ptr] : '0;
  assign overflow = r_overflow;
  assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_bcnn_popcount_drain.sv
// Directed bench for bcnn_popcount_drain: packing, flush, FIFO full/overflow and reset behaviour.
module tb_bcnn_popcount_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [3:0] sum_in;
  logic [3:0] thr;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_len;
  logic       overflow;
  logic [3:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];  // popped words as {len, data}

  bcnn_popcount_drain #(.SUM_WIDTH(4), .PACK_WIDTH(8), .FIFO_DEPTH(4), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sum_in(sum_in), .thr(thr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .overflow(overflow), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) q.push_back({out_len, out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] s, input logic f);
    valid_in = 1'b1;
    sum_in   = s;
    flush    = f;
    tick();
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  // Bits of w, LSB first, as sums of 9 (above) or 0 (below) a threshold of 5.
  task automatic send_bits(input logic [7:0] w, input int n, input logic flush_last);
    for (int i = 0; i < n; i++) sample(w[i] ? 4'd9 : 4'd0, flush_last && (i == n - 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++; if (out_len !== 4'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", out_len); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bitcnt got %0d exp 0", bit_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL empty_pop valid %b q %0d exp 0 0", out_valid, q.size()); end
  endtask

  task automatic test_full_word();
    logic [3:0] sums [8] = '{4'd9, 4'd0, 4'd5, 4'd4, 4'd7, 4'd5, 4'd1, 4'd6};
    thr = 4'd5;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) sample(sums[i], 1'b0);
    checks++; if (out_valid !== 1'b0 || bit_cnt !== 4'd7) begin errors++; $display("FAIL word_pre valid %b bitcnt %0d exp 0 7", out_valid, bit_cnt); end
    sample(sums[7], 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL word_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hB5) begin errors++; $display("FAIL word_data got %h exp b5", out_data); end
    checks++; if (out_len !== 4'd8) begin errors++; $display("FAIL word_len got %0d exp 8", out_len); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL word_bitcnt got %0d exp 0", bit_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL word_one_cycle got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    thr = 4'd3;
    q.delete();
    sample(4'd3, 1'b0); sample(4'd2, 1'b0); sample(4'd4, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h05 || out_len !== 4'd3) begin
      errors++; $display("FAIL flush_word valid %b data %h len %0d exp 1 05 3", out_valid, out_data, out_len); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL flush_bitcnt got %0d exp 0", bit_cnt); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || q.size() != 1) begin errors++; $display("FAIL flush_empty valid %b q %0d exp 0 1", out_valid, q.size()); end
  endtask

  task automatic test_thr_zero();
    thr = 4'd0;
    q.delete();
    for (int i = 0; i < 4; i++) sample(4'd0, i == 3);
    tick(); tick();
    checks++; if (q.size() != 1 || q[0] !== {4'd4, 8'h0F}) begin
      errors++; $display("FAIL thr_zero q %0d head %h exp 1 40f", q.size(), q.size() ? q[0] : 12'h0); end
  endtask

  task automatic test_overflow();
    thr = 4'd1;
    out_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) sample(4'd9, 1'b0);
    checks++; if (overflow !== 1'b0 || out_data !== 8'hFF) begin errors++; $display("FAIL ovf_pre ovf %b data %h exp 0 ff", overflow, out_data); end
    for (int i = 0; i < 8; i++) sample(4'd9, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (q.size() != 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", q.size()); end
    for (int i = 0; i < q.size(); i++) begin
      checks++; if (q[i] !== {4'd8, 8'hFF}) begin errors++; $display("FAIL ovf_word%0d got %h exp 8ff", i, q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    thr = 4'd5;
    out_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) send_bits(words[i], 8, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL full_hold valid %b data %h exp 1 11", out_valid, out_data); end
    send_bits(words[4], 7, 1'b0);
    out_ready = 1'b1;
    sample(4'd0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got %b exp 0", overflow); end
    checks++; if (q.size() != 5) begin errors++; $display("FAIL full_count got %0d exp 5", q.size()); end
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checks++; if (q[i] !== {4'd8, words[i]}) begin errors++; $display("FAIL full_word%0d got %h exp 8%h", i, q[i], words[i]); end
    end
  endtask

  task automatic test_flush_with_valid();
    thr = 4'd5;
    out_ready = 1'b1;
    q.delete();
    send_bits(8'h4B, 7, 1'b1);
    tick();
    send_bits(8'hC3, 8, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (q.size() != 2) begin errors++; $display("FAIL fv_count got %0d exp 2", q.size()); end
    checks++; if (q.size() > 0 && q[0] !== {4'd7, 8'h4B}) begin errors++; $display("FAIL fv_word7 got %h exp 74b", q[0]); end
    checks++; if (q.size() > 1 && q[1] !== {4'd8, 8'hC3}) begin errors++; $display("FAIL fv_word8 got %h exp 8c3", q[1]); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL fv_bitcnt got %0d exp 0", bit_cnt); end
  endtask

  task automatic test_reset_midstream();
    thr = 4'd5;
    out_ready = 1'b0;
    send_bits(8'hAA, 8, 1'b0);
    send_bits(8'hBB, 8, 1'b0);
    send_bits(8'h1F, 5, 1'b0);
    checks++; if (bit_cnt !== 4'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre bitcnt %0d valid %b exp 5 1", bit_cnt, out_valid); end
    do_reset();
    checks++; if (out_valid !== 1'b0 || bit_cnt !== 4'd0 || out_data !== 8'h00 || out_len !== 4'd0) begin
      errors++; $display("FAIL mid_reset valid %b bitcnt %0d data %h len %0d exp 0 0 00 0", out_valid, bit_cnt, out_data, out_len); end
    q.delete();
    out_ready = 1'b1;
    send_bits(8'h5A, 8, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (q.size() != 1 || q[0] !== {4'd8, 8'h5A}) begin
      errors++; $display("FAIL mid_post q %0d head %h exp 1 85a", q.size(), q.size() ? q[0] : 12'h0); end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; sum_in = '0; thr = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    test_reset();
    test_full_word();
    test_flush();
    test_thr_zero();
    test_overflow();
    test_full_push_pop();
    test_flush_with_valid();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
